// File: rtl/fetch_pkg.sv
// Shared fetch-front-end types and helpers for fetch_queue.
// FETCH_QUEUE_MISALIGN_CHECK_EN adds the fault bit to fetch_entry_t.
package fetch_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int FETCH_XLEN  = 32;

   // Canonical 32-bit entry layout seen by decode.
   typedef struct packed {
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
      logic                  fault;
`endif
      logic [FETCH_XLEN-1:0] instruction;
      logic [FETCH_XLEN-1:0] address;
      logic [FETCH_XLEN-1:0] next_address;
   } fetch_entry_t;

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; a push in the flush cycle lands as the only entry.
// Storage is not reset; the head reads as zero whenever the FIFO is empty.
module fetch_fifo #(
   parameter  int WIDTH = 96,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= AW'(push);
         count  <= CW'(push);
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_pop)
            count <= count + 1'b1;
         else if (!push && do_pop)
            count <= count - 1'b1;
      end
   end

   // When full, push+pop rewrites the slot being read this cycle; the read wins.
   always_ff @(posedge clk) begin
      if (push)
         mem[flush ? '0 : wr_ptr] <= push_data;
   end

   assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one request at a time, buffers entries.
// FETCH_QUEUE_MISALIGN_CHECK_EN enables misaligned-redirect faulting and the fault port.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            jump_enable,
   input  logic [XLEN-1:0] jump_address,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_address,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instruction,
   output logic [XLEN-1:0] out_address,
   output logic [XLEN-1:0] out_next_address
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
   ,
   output logic            fault
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
      logic            fault;
`endif
      logic [XLEN-1:0] instruction;
      logic [XLEN-1:0] address;
      logic [XLEN-1:0] next_address;
   } entry_t;

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] a);
      return a + XLEN'(INSTR_BYTES);
   endfunction

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic            outstanding;
   logic [CW-1:0]   count;
   logic [CW:0]     credit;
   logic            resp_take;
   logic            req_fire;
   logic            push;
   logic            pop;
   logic            faulted;
   logic            bad_jump;
   entry_t          push_entry;
   entry_t          head;

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
   assign bad_jump = jump_enable && (jump_address[1:0] != 2'b00);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         faulted <= 1'b0;
      else if (jump_enable)
         faulted <= bad_jump;
   end

   assign fault = head.fault;
`else
   assign bad_jump = 1'b0;
   assign faulted  = 1'b0;
`endif

   // In-flight slot counts against FIFO space so a response can always be pushed.
   assign credit         = {1'b0, count} + {{CW{1'b0}}, outstanding};
   assign imem_req_valid = !reset && !(outstanding && !imem_resp_valid) &&
                           (credit < (CW+1)'(DEPTH)) && !jump_enable && !faulted;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_take      = imem_resp_valid && outstanding;
   assign push           = jump_enable ? bad_jump : resp_take;
   assign pop            = out_valid && out_ready && !jump_enable;

   always_comb begin
      push_entry              = '0;
      push_entry.instruction  = imem_resp_data;
      push_entry.address      = req_addr;
      push_entry.next_address = next_pc(req_addr);
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
      if (bad_jump) begin
         push_entry.instruction  = '0;
         push_entry.address      = jump_address;
         push_entry.next_address = next_pc(jump_address);
         push_entry.fault        = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         outstanding <= 1'b0;
      end else if (jump_enable) begin
         pc          <= jump_address;
         outstanding <= 1'b0;
      end else if (req_fire) begin
         pc          <= next_pc(pc);
         outstanding <= 1'b1;
      end else if (resp_take) begin
         outstanding <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire)
         req_addr <= pc;
   end

   fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (jump_enable),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign imem_req_address = pc;
   assign out_valid        = (count != '0);
   assign out_instruction  = head.instruction;
   assign out_address      = head.address;
   assign out_next_address = head.next_address;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order memory model plus an entry scoreboard.
// Build with FETCH_QUEUE_MISALIGN_CHECK_EN to exercise the fault port as well.
module tb_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h100;

   logic        clk = 1'b0;
   logic        reset;
   logic        jump_enable;
   logic [31:0] jump_address;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_address;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_address;
   logic [31:0] out_next_address;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
   logic        fault;
`endif

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk              (clk),
      .reset            (reset),
      .jump_enable      (jump_enable),
      .jump_address     (jump_address),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_address (imem_req_address),
      .imem_resp_valid  (imem_resp_valid),
      .imem_resp_data   (imem_resp_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instruction  (out_instruction),
      .out_address      (out_address),
      .out_next_address (out_next_address)
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
      ,
      .fault            (fault)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic [31:0] next;
      logic        flt;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
      bit          stale;
   } mreq_t;

   exp_t        expq[$];
   mreq_t       pend[$];
   mreq_t       cur;
   bit          have_cur;
   logic [31:0] model_pc;
   bit          model_fault;
   int          cyc, lat_min, lat_max, total, bad, n_req, n_pop;
   bit          rnd_stall;
   logic        s_req_valid, s_out_valid;
   logic [31:0] s_req_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: memory drives, pre-edge checks, edge, model update.
   task automatic tick();
      exp_t e;
      int   inflight;
      have_cur        = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         cur             = pend.pop_front();
         have_cur        = 1'b1;
         imem_resp_valid = 1'b1;
         imem_resp_data  = cur.data;
      end
      imem_req_ready = (pend.size() == 0) && !(rnd_stall && $urandom_range(3) == 0);
      #2;
      s_req_valid = imem_req_valid;
      s_req_addr  = imem_req_address;
      s_out_valid = out_valid;
      check("out_valid", 32'(out_valid), 32'(expq.size() != 0));
      if (out_valid && expq.size() != 0) begin
         e = expq[0];
         check("out_address", out_address, e.addr);
         check("out_instruction", out_instruction, e.instr);
         check("out_next_address", out_next_address, e.next);
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
         check("out_fault", 32'(fault), 32'(e.flt));
`endif
      end
      if (imem_req_valid)
         check("req_address", imem_req_address, model_pc);
      if (jump_enable || model_fault)
         check("req_blocked", 32'(imem_req_valid), 32'd0);
      @(posedge clk);
      #1;
      if (jump_enable) begin
         expq.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         model_pc    = jump_address;
         model_fault = 1'b0;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
         if (jump_address[1:0] != 2'b00) begin
            model_fault = 1'b1;
            expq.push_back('{32'h0, jump_address, jump_address + 32'd4, 1'b1});
         end
`endif
      end else begin
         if (s_out_valid && out_ready && expq.size() != 0) begin
            e = expq.pop_front();
            n_pop++;
         end
         if (have_cur && !cur.stale)
            expq.push_back('{cur.data, cur.addr, cur.addr + 32'd4, 1'b0});
         if (s_req_valid && imem_req_ready) begin
            pend.push_back('{model_pc, $urandom, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
            model_pc = model_pc + 32'd4;
            n_req++;
         end
      end
      inflight = 0;
      foreach (pend[i]) if (!pend[i].stale) inflight++;
      check("credit", 32'(expq.size() + inflight <= DEPTH), 32'd1);
      cyc++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check({tag, "_req_address"}, imem_req_address, RPC);
      check({tag, "_out_instruction"}, out_instruction, 32'd0);
      check({tag, "_out_address"}, out_address, 32'd0);
      check({tag, "_out_next_address"}, out_next_address, 32'd0);
   endtask

   task automatic redirect(input logic [31:0] target);
      jump_address = target;
      jump_enable  = 1'b1;
      tick();
      jump_enable  = 1'b0;
   endtask

   // Advance until the next tick would not deliver the outstanding response.
   task automatic wait_outstanding(input string tag);
      bit found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         if (pend.size() != 0 && !pend[0].stale && pend[0].due > cyc)
            found = 1'b1;
         else
            tick();
      end
      check(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_out_valid(input string tag);
      bit found = 1'b0;
      for (int k = 0; k < 15 && !found; k++) begin
         tick();
         found = out_valid;
      end
      check(tag, 32'(found), 32'd1);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; n_req = 0; n_pop = 0;
      reset = 1'b1; jump_enable = 1'b0; jump_address = '0;
      out_ready = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      lat_min = 1; lat_max = 1; rnd_stall = 1'b0;
      model_pc = RPC; model_fault = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;

      // Sequential fetch from RESET_PC with 1-cycle memory
      tick();
      check("first_req_valid", 32'(s_req_valid), 32'd1);
      check("first_req_address", s_req_addr, 32'h100);
      repeat (2) tick();
      n_pop = 0;
      repeat (8) tick();
      check("throughput_pops", 32'(n_pop), 32'd8);

      // Back-pressure: the credit rule stops issue at DEPTH requests
      redirect(32'h180);
      out_ready = 1'b0;
      n_req = 0;
      repeat (8) tick();
      check("bp_requests", 32'(n_req), 32'd4);
      check("bp_req_valid_low", 32'(s_req_valid), 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp_hold_during_pop", 32'(s_req_valid), 32'd0);
      tick();
      check("bp_resume", 32'(s_req_valid), 32'd1);

      // Redirect while a 3-cycle request is outstanding
      lat_min = 3; lat_max = 3;
      repeat (4) tick();
      wait_outstanding("t3_outstanding");
      redirect(32'h200);
      wait_out_valid("t3_out_valid");
      check("t3_first_address", out_address, 32'h200);

      // Redirect coinciding with a response and a pop
      lat_min = 1; lat_max = 1;
      repeat (5) tick();
      check("t4_setup", 32'(pend.size() != 0 && pend[0].due <= cyc && out_valid), 32'd1);
      redirect(32'h200);
      check("t4_empty_after", 32'(out_valid), 32'd0);
      tick();
      check("t4_req_valid", 32'(s_req_valid), 32'd1);
      check("t4_req_address", s_req_addr, 32'h200);
      tick();
      check("t4_out_valid_t3", 32'(out_valid), 32'd1);
      check("t4_out_address", out_address, 32'h200);

      // Asynchronous reset with a request outstanding
      lat_min = 3; lat_max = 3;
      repeat (3) tick();
      wait_outstanding("t5_outstanding");
      #1 reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      reset = 1'b0;
      expq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      model_pc = RPC;
      model_fault = 1'b0;
      wait_out_valid("t5_out_valid");
      check("t5_restart_address", out_address, RPC);

      // Address wrap, then random traffic with stalls and redirects
      lat_min = 1; lat_max = 3; rnd_stall = 1'b1;
      redirect(32'hFFFF_FFF8);
      repeat (12) tick();
      for (int i = 0; i < 400; i++) begin
         out_ready    = ($urandom_range(3) != 0);
         jump_enable  = ($urandom_range(29) == 0);
         jump_address = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      jump_enable = 1'b0;
      out_ready   = 1'b1;
      rnd_stall   = 1'b0;
      lat_min = 1; lat_max = 1;
      repeat (6) tick();

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
      // Misaligned redirect: single fault entry, issue frozen until aligned redirect
      redirect(32'h202);
      check("fault_out_valid", 32'(out_valid), 32'd1);
      check("fault_flag", 32'(fault), 32'd1);
      check("fault_address", out_address, 32'h202);
      check("fault_instruction", out_instruction, 32'd0);
      n_req = 0;
      repeat (6) tick();
      check("fault_no_requests", 32'(n_req), 32'd0);
      check("fault_drained", 32'(out_valid), 32'd0);
      redirect(32'h300);
      tick();
      check("fault_clear_req_valid", 32'(s_req_valid), 32'd1);
      check("fault_clear_req_address", s_req_address_or(s_req_addr), 32'h300);
      repeat (4) tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   function automatic logic [31:0] s_req_address_or(input logic [31:0] a);
      return a;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end

endmodule
